prime_stepper: RTL and testbench

Advances through the prime numbers one step per button press. It consumes the single-cycle `pressed` pulse from the debounced button stage and searches for the next prime above the current value by trial division using repeated subtraction, with no divider or multiplier. The result drives the LED/display logic downstream. It holds its value between presses and wraps to 2 when the counter range is exhausted.

---
 rtl/prime_stepper.sv | 117 +++++++++++
 tb/tb_prime_stepper.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/prime_stepper.sv
// rtl/prime_stepper.sv - next-prime search by trial division via repeated subtraction
module prime_stepper #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_i,
    output logic [WIDTH-1:0] prime_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             wrap_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAND = 2'd1,
        TEST = 2'd2,
        SUB  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [WIDTH:0]     cand, cand_n;
    logic [WIDTH-1:0]   d, d_n;
    logic [2*WIDTH-1:0] sq, sq_n;
    logic [WIDTH:0]     r, r_n;
    logic [WIDTH-1:0]   prime_n;
    logic               done_n, wrap_n;

    logic [2*WIDTH-1:0] cand_wide;
    logic [WIDTH:0]     d_ext;

    assign cand_wide = {{(WIDTH-1){1'b0}}, cand};
    assign d_ext     = {1'b0, d};
    assign busy_o    = (state != IDLE);

    // State and datapath registers; reset abandons any search in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cand    <= '0;
            d       <= '0;
            sq      <= '0;
            r       <= '0;
            prime_o <= WIDTH'(2);
            done_o  <= 1'b0;
            wrap_o  <= 1'b0;
        end else begin
            state   <= state_n;
            cand    <= cand_n;
            d       <= d_n;
            sq      <= sq_n;
            r       <= r_n;
            prime_o <= prime_n;
            done_o  <= done_n;
            wrap_o  <= wrap_n;
        end
    end

    // Next-state and datapath updates; registers hold unless a state changes them
    always_comb begin
        state_n = state;
        cand_n  = cand;
        d_n     = d;
        sq_n    = sq;
        r_n     = r;
        prime_n = prime_o;
        done_n  = 1'b0;
        wrap_n  = 1'b0;
        case (state)
            IDLE: begin
                if (step_i) begin
                    cand_n  = {1'b0, prime_o} + (WIDTH+1)'(1);
                    state_n = CAND;
                end
            end
            CAND: begin
                if (cand[WIDTH]) begin
                    // candidate ran past the counter range: start over at 2
                    prime_n = WIDTH'(2);
                    wrap_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    d_n     = WIDTH'(2);
                    sq_n    = (2*WIDTH)'(4);
                    r_n     = cand;
                    state_n = TEST;
                end
            end
            TEST: begin
                // no divisor up to sqrt(cand) divided it
                if (sq > cand_wide) begin
                    prime_n = cand[WIDTH-1:0];
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = SUB;
                end
            end
            SUB: begin
                if (r >= d_ext) begin
                    r_n = r - d_ext;
                end else if (r == '0) begin
                    cand_n  = cand + (WIDTH+1)'(1);
                    state_n = CAND;
                end else begin
                    // (d+1)^2 = d^2 + 2d + 1
                    d_n     = d + WIDTH'(1);
                    sq_n    = sq + {{(WIDTH-1){1'b0}}, d, 1'b1};
                    r_n     = cand;
                    state_n = TEST;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prime_stepper.sv
// tb/tb_prime_stepper.sv - self-checking bench for prime_stepper
module tb_prime_stepper;

    logic       clk;
    logic       rst_n;
    logic       step_i;
    logic [7:0] prime_o;
    logic       busy_o;
    logic       done_o;
    logic       wrap_o;

    int applied;
    int miscompares;

    prime_stepper #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_i  (step_i),
        .prime_o (prime_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .wrap_o  (wrap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp_prime;
        logic       exp_done;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[54];
    int   primes_ref[53] = '{
        3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61, 67,
        71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 127, 131, 137, 139,
        149, 151, 157, 163, 167, 173, 179, 181, 191, 193, 197, 199, 211, 223,
        227, 229, 233, 239, 241, 251
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one-cycle step pulse sampled on the next edge
    task automatic pulse_step();
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
    endtask

    // edges after the step edge until done_o or wrap_o; -1 on timeout
    task automatic wait_result(output int edges, output logic got_done, output logic got_wrap);
        edges    = -1;
        got_done = 1'b0;
        got_wrap = 1'b0;
        for (int i = 1; i <= 3000; i++) begin
            tick();
            if (done_o || wrap_o) begin
                edges    = i;
                got_done = done_o;
                got_wrap = wrap_o;
                break;
            end
        end
        if (edges < 0) begin
            applied++;
            miscompares++;
            $display("FAIL timeout: no done_o/wrap_o within 3000 cycles");
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int   edges;
    logic got_done, got_wrap;
    logic seen_done;

    initial begin
        applied     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        step_i      = 1'b0;

        for (int i = 0; i < 53; i++) begin
            vecs[i].exp_prime = 8'(primes_ref[i]);
            vecs[i].exp_done  = 1'b1;
            vecs[i].exp_wrap  = 1'b0;
        end
        vecs[53].exp_prime = 8'd2;
        vecs[53].exp_done  = 1'b0;
        vecs[53].exp_wrap  = 1'b1;

        // reset held 3 cycles with step_i toggling
        for (int i = 0; i < 3; i++) begin
            step_i = i[0];
            tick();
            check("rst_prime", 32'(prime_o), 2);
            check("rst_busy", 32'(busy_o), 0);
            check("rst_done_wrap", 32'({done_o, wrap_o}), 0);
        end
        step_i = 1'b0;
        rst_n  = 1'b1;
        tick();
        check("post_rst_prime", 32'(prime_o), 2);
        check("post_rst_busy", 32'(busy_o), 0);

        // short latency 2 -> 3
        pulse_step();
        check("short_busy_k1", 32'(busy_o), 1);
        tick();
        check("short_busy_k2", 32'(busy_o), 1);
        check("short_done_early", 32'(done_o), 0);
        tick();
        check("short_done", 32'(done_o), 1);
        check("short_busy_end", 32'(busy_o), 0);
        check("short_prime", 32'(prime_o), 3);
        tick();
        check("short_done_one_cycle", 32'(done_o), 0);

        // 3 -> 5 with stray steps while busy, including on the returning edge
        pulse_step();
        edges = -1;
        for (int i = 2; i <= 40; i++) begin
            step_i = (i == 3 || i == 6 || i == 9 || i == 12);
            tick();
            step_i = 1'b0;
            if (done_o) begin
                edges = i - 1;
                break;
            end
        end
        check("skip_latency", 32'(edges), 11);
        check("skip_prime", 32'(prime_o), 5);
        // step on the cycle after done_o is accepted
        pulse_step();
        check("b2b_busy", 32'(busy_o), 1);
        wait_result(edges, got_done, got_wrap);
        check("b2b_done", 32'(got_done), 1);
        check("b2b_prime", 32'(prime_o), 7);

        // reset during the 7 -> 11 search
        pulse_step();
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy_before", 32'(busy_o), 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_prime", 32'(prime_o), 2);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_done", 32'(done_o), 0);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen_done = seen_done | done_o;
        end
        check("mid_no_done", 32'(seen_done), 0);
        check("mid_idle_prime", 32'(prime_o), 2);
        pulse_step();
        wait_result(edges, got_done, got_wrap);
        check("mid_after_prime", 32'(prime_o), 3);

        // full sweep from reset through the wrap
        do_reset();
        for (int v = 0; v < 54; v++) begin
            pulse_step();
            wait_result(edges, got_done, got_wrap);
            check($sformatf("sweep%0d_prime", v), 32'(prime_o), 32'(vecs[v].exp_prime));
            check($sformatf("sweep%0d_done", v), 32'(got_done), 32'(vecs[v].exp_done));
            check($sformatf("sweep%0d_wrap", v), 32'(got_wrap), 32'(vecs[v].exp_wrap));
            check($sformatf("sweep%0d_busy", v), 32'(busy_o), 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
